// File: rtl/output_framer.sv
// Output framer: serialises IN_W-bit result beats into OUT_W-bit TX FIFO words,
// tracks bytes per frame across beats, and zero-pads partial frames on flush.
//
// state | meaning
// IDLE  | waiting for a beat or a flush request
// PARSE | writing the words of the latched beat
// PAD   | writing PAD_WORD until the frame boundary
module output_framer #(
  parameter int          IN_W        = 128,
  parameter int          OUT_W       = 32,
  parameter int          FRAME_BYTES = 1024,
  parameter bit          MSB_FIRST   = 1'b0,
  parameter logic [OUT_W-1:0] PAD_WORD = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  data_flat,
  input  logic             data_ready,
  input  logic             data_idle,
  input  logic             fifo_full,
  output logic             parser_busy,
  output logic [OUT_W-1:0] FIFO_tx_din,
  output logic             FIFO_tx_enable,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  localparam int WPB = IN_W / OUT_W;
  localparam int WB  = OUT_W / 8;
  localparam int BCW = $clog2(FRAME_BYTES);
  localparam int WIW = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [1:0] {IDLE, PARSE, PAD} state_t;

  state_t           state;
  logic [IN_W-1:0]  beat_reg;
  logic [WIW-1:0]   word_idx;
  logic [BCW-1:0]   byte_cnt;
  logic             flush_pend;

  logic [BCW:0]     byte_sum;
  logic             frame_end;
  logic [BCW-1:0]   byte_next;
  logic             last_word;
  logic [OUT_W-1:0] chunk [WPB];

  // Word slices of the latched beat, already in transmit order.
  for (genvar g = 0; g < WPB; g++) begin : g_chunk
    localparam int SEL = MSB_FIRST ? (WPB - 1 - g) : g;
    assign chunk[g] = beat_reg[SEL*OUT_W +: OUT_W];
  end

  // Byte count after the current write; a frame closes when it hits FRAME_BYTES.
  always_comb begin
    byte_sum  = {1'b0, byte_cnt} + (BCW+1)'(WB);
    frame_end = (byte_sum == (BCW+1)'(FRAME_BYTES));
    byte_next = frame_end ? '0 : byte_sum[BCW-1:0];
    last_word = (word_idx == WIW'(WPB - 1));
  end

  // Sequencer: accept beats, emit words, pad on flush, stall on fifo_full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      beat_reg       <= '0;
      word_idx       <= '0;
      byte_cnt       <= '0;
      flush_pend     <= 1'b0;
      parser_busy    <= 1'b0;
      FIFO_tx_din    <= '0;
      FIFO_tx_enable <= 1'b0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
    end else begin
      FIFO_tx_enable <= 1'b0;
      frame_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (data_ready) begin
            beat_reg    <= data_flat;
            word_idx    <= '0;
            flush_pend  <= data_idle;
            parser_busy <= 1'b1;
            state       <= PARSE;
          end else if (data_idle && byte_cnt != '0) begin
            parser_busy <= 1'b1;
            state       <= PAD;
          end
        end
        PARSE: begin
          if (!fifo_full) begin
            FIFO_tx_enable <= 1'b1;
            FIFO_tx_din    <= chunk[word_idx];
            byte_cnt       <= byte_next;
            if (frame_end) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end
            if (last_word) begin
              // A flush that lands exactly on a boundary has nothing to pad.
              if (flush_pend && !frame_end) begin
                state <= PAD;
              end else begin
                state       <= IDLE;
                parser_busy <= 1'b0;
                flush_pend  <= 1'b0;
              end
            end else begin
              word_idx <= word_idx + WIW'(1);
            end
          end
        end
        PAD: begin
          if (!fifo_full) begin
            FIFO_tx_enable <= 1'b1;
            FIFO_tx_din    <= PAD_WORD;
            byte_cnt       <= byte_next;
            if (frame_end) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              state       <= IDLE;
              parser_busy <= 1'b0;
              flush_pend  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_framer.sv
// Scoreboard bench for output_framer: default build (A) and a 64->16 MSB-first build (B).
module tb_output_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] a_data = '0;
  logic a_ready = 0, a_idle = 0, a_full = 0;
  logic a_busy, a_en, a_done;
  logic [31:0] a_din;
  logic [15:0] a_fc;

  logic [63:0] b_data = '0;
  logic b_ready = 0, b_idle = 0, b_full = 0;
  logic b_busy, b_en, b_done;
  logic [15:0] b_din;
  logic [15:0] b_fc;

  output_framer dut_a (
    .clk(clk), .rst(rst), .data_flat(a_data), .data_ready(a_ready), .data_idle(a_idle),
    .fifo_full(a_full), .parser_busy(a_busy), .FIFO_tx_din(a_din), .FIFO_tx_enable(a_en),
    .frame_done(a_done), .frame_count(a_fc)
  );

  output_framer #(.IN_W(64), .OUT_W(16), .FRAME_BYTES(32), .MSB_FIRST(1'b1),
                  .PAD_WORD(16'hE0E0)) dut_b (
    .clk(clk), .rst(rst), .data_flat(b_data), .data_ready(b_ready), .data_idle(b_idle),
    .fifo_full(b_full), .parser_busy(b_busy), .FIFO_tx_din(b_din), .FIFO_tx_enable(b_en),
    .frame_done(b_done), .frame_count(b_fc)
  );

  typedef struct packed {logic [31:0] d; logic done;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int checks = 0, errors = 0;
  int a_bytes = 0, a_frames = 0, b_bytes = 0, b_frames = 0;
  int a_wr = 0, b_wr = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_a(logic [31:0] w);
    a_bytes += 4;
    if (a_bytes == 1024) begin
      a_bytes = 0; a_frames++; qa.push_back('{d: w, done: 1'b1});
    end else qa.push_back('{d: w, done: 1'b0});
  endtask

  task automatic push_b(logic [15:0] w);
    b_bytes += 2;
    if (b_bytes == 32) begin
      b_bytes = 0; b_frames++; qb.push_back('{d: 32'(w), done: 1'b1});
    end else qb.push_back('{d: 32'(w), done: 1'b0});
  endtask

  // Monitor A: every written word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_en) begin
        a_wr++;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_write: got %0h want none", a_din);
        end else begin
          ea = qa.pop_front();
          check("a_din", a_din, ea.d);
          check("a_frame_done", 32'(a_done), 32'(ea.done));
        end
      end else if (a_done) begin
        checks++; errors++;
        $display("FAIL a_done_without_write: got 1 want 0");
      end
    end
  end

  // Monitor B: same scoreboard discipline for the narrow build.
  always @(negedge clk) begin
    if (!rst) begin
      if (b_en) begin
        b_wr++;
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_write: got %0h want none", b_din);
        end else begin
          eb = qb.pop_front();
          check("b_din", 32'(b_din), eb.d);
          check("b_frame_done", 32'(b_done), 32'(eb.done));
        end
      end else if (b_done) begin
        checks++; errors++;
        $display("FAIL b_done_without_write: got 1 want 0");
      end
    end
  end

  task automatic wait_free_a();
    int t = 0;
    while (a_busy && t < 3000) begin @(posedge clk); #1; t++; end
    if (a_busy) begin checks++; errors++; $display("FAIL a_busy_timeout: got busy want idle"); end
  endtask

  task automatic wait_free_b();
    int t = 0;
    while (b_busy && t < 3000) begin @(posedge clk); #1; t++; end
    if (b_busy) begin checks++; errors++; $display("FAIL b_busy_timeout: got busy want idle"); end
  endtask

  task automatic send_a(logic [127:0] d, logic idle);
    wait_free_a();
    a_data = d; a_ready = 1'b1; a_idle = idle;
    for (int k = 0; k < 4; k++) push_a(d[k*32 +: 32]);
    if (idle) while (a_bytes != 0) push_a(32'h0);
    @(posedge clk); #1;
    a_ready = 1'b0; a_idle = 1'b0;
  endtask

  task automatic flush_a();
    wait_free_a();
    a_idle = 1'b1;
    while (a_bytes != 0) push_a(32'h0);
    @(posedge clk); #1;
    a_idle = 1'b0;
  endtask

  task automatic drain_a(string name);
    wait_free_a();
    @(posedge clk); #1;
    check(name, qa.size(), 0);
    check({name, "_fc"}, 32'(a_fc), 32'(a_frames));
  endtask

  task automatic send_b(logic [63:0] d, logic idle);
    wait_free_b();
    b_data = d; b_ready = 1'b1; b_idle = idle;
    for (int k = 3; k >= 0; k--) push_b(d[k*16 +: 16]);
    if (idle) while (b_bytes != 0) push_b(16'hE0E0);
    @(posedge clk); #1;
    b_ready = 1'b0; b_idle = 1'b0;
  endtask

  task automatic flush_b();
    wait_free_b();
    b_idle = 1'b1;
    while (b_bytes != 0) push_b(16'hE0E0);
    @(posedge clk); #1;
    b_idle = 1'b0;
  endtask

  task automatic drain_b(string name);
    wait_free_b();
    @(posedge clk); #1;
    check(name, qb.size(), 0);
    check({name, "_fc"}, 32'(b_fc), 32'(b_frames));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int n, w0, t;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 32'(a_busy), 0);
    check("rst_en", 32'(a_en), 0);
    check("rst_din", a_din, 0);
    check("rst_fc", 32'(a_fc), 0);
    check("rst_b_fc", 32'(b_fc), 0);
    @(posedge clk); #1;

    // Single beat, word order, latency and busy length; then flush pads 252 words.
    send_a(128'h44444444_33333333_22222222_11111111, 1'b0);
    n = 0;
    while (a_busy && n < 100) begin
      if (n == 0) check("lat_first_en", 32'(a_en), 0);
      if (n == 1) check("lat_second_en", 32'(a_en), 1);
      @(posedge clk); #1; n++;
    end
    check("busy_cycles", n, 4);
    check("no_frame_yet", 32'(a_fc), 0);
    flush_a();
    drain_a("t1_drain");

    // 64 back-to-back beats close exactly one frame; a trailing flush emits nothing.
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'hA5000000 | 32'(i << 4) | 32'(k);
      send_a(d, 1'b0);
    end
    drain_a("t2_drain");
    flush_a();
    repeat (5) @(posedge clk); #1;
    check("t2_empty_flush_busy", 32'(a_busy), 0);
    drain_a("t2b_drain");

    // Flush sampled at acceptance: 4 data words then 252 pads.
    send_a(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b1);
    drain_a("t3_drain");
    check("t3_busy_low", 32'(a_busy), 0);

    // Backpressure: fifo_full for 3 cycles after word 2.
    w0 = a_wr;
    send_a(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_en", 32'(a_en), 0);
      check("stall_busy", 32'(a_busy), 1);
    end
    a_full = 1'b0;
    @(posedge clk); #1;
    check("resume_en", 32'(a_en), 1);
    drain_a("t4_drain");
    check("t4_writes", a_wr - w0, 4);
    flush_a();
    drain_a("t4b_drain");

    // Narrow MSB-first build: one beat, flush to 12 pads, then beat with flush.
    send_b(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    flush_b();
    drain_b("b1_drain");
    send_b(64'h1357_2468_9BDF_ACE0, 1'b1);
    drain_b("b2_drain");
    check("b_fc_final", 32'(b_fc), 2);

    // Reset in the middle of a pad run.
    w0 = a_wr;
    send_a(128'h44444444_33333333_22222222_11111111, 1'b1);
    t = 0;
    while (a_wr < w0 + 104 && t < 2000) begin @(posedge clk); #1; t++; end
    check("t6_reached_pad", 32'(a_wr >= w0 + 104), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_en", 32'(a_en), 0);
    check("arst_din", a_din, 0);
    check("arst_busy", 32'(a_busy), 0);
    check("arst_done", 32'(a_done), 0);
    check("arst_fc", 32'(a_fc), 0);
    qa.delete(); a_bytes = 0; a_frames = 0;
    @(posedge clk); #1 rst = 1'b0;
    flush_a();
    repeat (5) @(posedge clk); #1;
    check("post_rst_busy", 32'(a_busy), 0);
    drain_a("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_framer.md
Name: output_framer

Overview:
- Parametrised successor to the fixed 128→32 output parser.
- Accepts IN_W-bit result beats and serialises each into OUT_W-bit words for the host TX FIFO.
- Keeps a byte count that persists across beats within a frame, honours FIFO backpressure, and on flush zero-pads the partial frame to a FRAME_BYTES boundary.
- Sits between the compute/result datapath and the TX FIFO feeding the host link.

Parameters:
- IN_W, 128, input beat width in bits; integer multiple of OUT_W.
- OUT_W, 32, FIFO word width in bits; multiple of 8.
- FRAME_BYTES, 1024, frame size in bytes; integer multiple of IN_W/8, so a beat never straddles a frame.
- MSB_FIRST, 0, word order within a beat: 0 = bits [OUT_W-1:0] first; 1 = top OUT_W bits first.
- PAD_WORD, 0, OUT_W-bit value written during padding.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- data_flat, in, IN_W, input beat; sampled only on the acceptance edge.
- data_ready, in, 1, beat valid; accepted on an edge where data_ready=1 and parser_busy=0.
- data_idle, in, 1, flush request: close the current partial frame with padding.
- fifo_full, in, 1, TX FIFO full; no word is written on an edge where it is 1.
- parser_busy, out, 1, high from the acceptance edge until the last word of a beat or pad run is written.
- FIFO_tx_din, out, OUT_W, word to FIFO (registered).
- FIFO_tx_enable, out, 1, FIFO write strobe; one cycle per word (registered).
- frame_done, out, 1, one-cycle pulse coincident with the write of the last word of each frame.
- frame_count, out, 16, completed frames since reset; wraps modulo 2^16.

Behaviour:
- Derived constants: WPB = IN_W/OUT_W words per beat; WB = OUT_W/8 bytes per word; byte_cnt width = clog2(FRAME_BYTES).
- Async reset values: state=IDLE, parser_busy=0, FIFO_tx_enable=0, FIFO_tx_din=0, frame_done=0, frame_count=0, byte_cnt=0, word_idx=0, flush_pend=0. Reset mid-beat or mid-pad discards all remaining words; no partial frame is resumed.
- IDLE:
  - data_ready=1 on an edge: latch data_flat into beat_reg; set word_idx=0; flush_pend<=data_idle; parser_busy<=1; go to PARSE.
  - Else if data_idle=1 and byte_cnt!=0: parser_busy<=1; go to PAD.
  - Else if data_idle=1 and byte_cnt==0: no action; an empty flush emits nothing.
- PARSE, evaluated each edge:
  - fifo_full=0: FIFO_tx_enable<=1; FIFO_tx_din<=chunk[word_idx], taken from the low or high end of beat_reg per MSB_FIRST; byte_cnt<=byte_cnt+WB, wrapping to 0 at FRAME_BYTES.
  - If that write completes the frame: frame_done<=1 and frame_count increments.
  - On the last word (word_idx=WPB-1): if flush_pend=1 and the post-write byte_cnt!=0, go to PAD; otherwise go to IDLE, parser_busy<=0, flush_pend<=0.
  - fifo_full=1: FIFO_tx_enable<=0; hold all state (stall, no word lost).
- PAD: same stall rule as PARSE.
  - Each write: FIFO_tx_din<=PAD_WORD; byte_cnt+=WB.
  - When byte_cnt reaches FRAME_BYTES-WB and the write occurs: frame_done pulse, frame_count+1, byte_cnt<=0, go to IDLE, parser_busy<=0.
  - data_ready is ignored while busy; the upstream holds it.
- Latency: first word's FIFO_tx_enable is high on the edge after acceptance. An unstalled beat takes WPB consecutive write cycles. parser_busy falls on the edge of the last write, so the next beat can be accepted one cycle later, giving WPB+1 cycles per beat.
- Byte accounting is continuous across beats: frame boundaries depend only on total words written since the last boundary.
- data_idle is level-sensitive in IDLE and sampled at acceptance in PARSE; an assertion during PARSE after acceptance is acted on at the next IDLE.

Test Plan:
- Defaults, one beat 0x44444444_33333333_22222222_11111111, fifo_full=0, data_idle=0 → four writes 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; busy high for 4 cycles; byte_cnt=16; no frame_done.
- 64 back-to-back beats → 256 writes, frame_done exactly once on write 256, frame_count=1, byte_cnt=0; a following data_idle emits nothing.
- One beat with data_idle=1 at acceptance → 4 data words, then 252 PAD_WORD writes; frame_done on write 256; busy low afterwards.
- fifo_full held high for 3 cycles after the second word → exactly 3 cycles with FIFO_tx_enable=0; words 3–4 are correct, with no drop or duplicate.
- MSB_FIRST=1, IN_W=64, OUT_W=16, FRAME_BYTES=32, beat 0xAAAA_BBBB_CCCC_DDDD → writes AAAA, BBBB, CCCC, DDDD; flush → 12 pad words, frame_done.
- rst asserted mid-PAD (after 100 pad words) → outputs zero immediately and asynchronously; after release, a flush emits nothing and frame_count=0.
